// File: rtl/six_bit_code_tx_if.sv
// Parallel code handshake between the local code source and the serial transmitter.
// The source drives code/valid; the transmitter answers with ready.
interface six_bit_code_tx_if;
    logic [5:0] code;
    logic       valid;
    logic       ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/six_bit_code_tx.sv
// Serializes a 6-bit code as start, a5..a0, optional even parity (SIX_BIT_TX_PARITY_EN), stop.
// Latency: start bit on txd the cycle after acceptance; frame is 8 (9 with parity) x CLKS_PER_BIT cycles.
// Backpressure: ready only in IDLE; valid is ignored while a frame is in flight, no queueing.
module six_bit_code_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    six_bit_code_tx_if.slave   src,
    output logic               txd,
    output logic               busy,
    output logic               done
);

`ifdef SIX_BIT_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [5:0] shreg;
    logic       ready_q;
`ifdef SIX_BIT_TX_PARITY_EN
    logic       par;
`endif

    logic bit_end;
    assign bit_end   = (cnt == LAST_CNT);
    assign src.ready = ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SIX_BIT_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (src.valid) begin
                        state   <= START;
                        shreg   <= src.code;
                        cnt     <= '0;
                        idx     <= '0;
                        txd     <= 1'b0;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
`ifdef SIX_BIT_TX_PARITY_EN
                        par     <= ^src.code;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= DATA;
                        txd   <= shreg[5];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {shreg[4:0], 1'b0};
                        if (idx == 3'd5) begin
                            idx   <= '0;
`ifdef SIX_BIT_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= par;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            // txd must show the next bit now, before the shift lands
                            idx <= idx + 3'd1;
                            txd <= shreg[4];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef SIX_BIT_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                        txd   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        txd     <= 1'b1;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/six_bit_code_tx.md
# six_bit_code_tx

Serializing transmitter for 6-bit codes. It accepts a parallel 6-bit word on a valid/ready handshake and shifts it out on a single line as an asynchronous-style frame. A remote serial receiver/comparator deserializes the frame and checks it bit-for-bit against its own 6-bit key. This block is the sending end of the code-match path and sits between the local code source and the serial link.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1–255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- code  input  6  word to send; code[5] corresponds to bit a5 and is sent first.
- valid  input  1  code is presented; the word is accepted on any rising edge where valid && ready.
- ready  output  1  high only in IDLE.
- txd  output  1  serial line; idles high.
- busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- done  output  1  one-cycle pulse in the first IDLE cycle after a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (only when compiled in), STOP.
- IDLE: txd=1, ready=1, busy=0.
  - On valid && ready: latch code into a 6-bit shift register, clear the bit-time counter and bit index, and go to START.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: txd = shreg[5], MSB first.
  - After each CLKS_PER_BIT cycles, shift left and increment the index.
  - After index 5 completes, go to PARITY if enabled, else STOP.
- PARITY: txd = even parity (XOR of the 6 latched bits) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for that single IDLE cycle.
- Changes on code after acceptance are ignored.
- valid is ignored while ready=0, and there is no queueing.
- Bit-time counter width is 8 bits and counts 0..CLKS_PER_BIT-1. Bit index is 3 bits.

## Timing
- Reset values: txd=1, ready=1, busy=0, done=0; state=IDLE; counters and shift register 0.
- Reset mid-frame: at the next edge with rst_n=0, the frame is abandoned. txd=1 and no done pulse is issued.
- Latency: the start bit appears on txd in the cycle after the accepting edge.
- Frame length: 8×CLKS_PER_BIT cycles, or 9×CLKS_PER_BIT with parity.
- Back-to-back sends: if valid is held, the next word is accepted in the done cycle. That leaves exactly one extra idle cycle (txd=1) between the stop bit and the next start bit.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle, with no extra stall cycles.
- done and ready are both high in the done cycle. busy=0 in that cycle.

## Configuration
- SIX_BIT_TX_PARITY_EN
  - Defined: the PARITY state is present. The frame is start, 6 data bits, even-parity bit, stop.
  - Undefined: the PARITY state and its logic are removed. The frame is start, 6 data bits, stop.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with valid=1 -> txd=1, ready=1, busy=0, done=0 throughout; nothing is accepted.
- Single frame, CLKS_PER_BIT=4, parity on, code=6'b101101 -> txd per bit is 0,1,0,1,1,0,1,0,1, each held 4 cycles (36 cycles total). done pulses at cycle 37 after acceptance.
- Same stimulus with parity off -> txd is 0,1,0,1,1,0,1,1 (32 cycles). code is changed to 6'b000000 mid-frame with no effect on txd.
- Back-to-back, CLKS_PER_BIT=1, parity on, valid held with 6'b111111 then 6'b000001 -> frames 0,1,1,1,1,1,1,0,1 then one idle 1, then 0,0,0,0,0,0,1,1,1.
- Reset mid-frame: rst_n=0 during DATA bit 3 -> txd=1 and ready=1 on the next edge, no done pulse. A new code accepted afterwards transmits correctly.
- Handshake: valid pulsed while busy=1 -> ignored. No second frame is sent after done.
